// File: rtl/explosion_controller.sv
// explosion_controller: queues bomb explosion requests, resolves the four flame
// arms of each one against the block map, keeps up to NUM_FLAMES flames alive
// for FLAME_TICKS clocks each, and flags pixels that fall inside a live flame.
// Optional feature macro: EXPLOSION_BRICK_CLEAR_EN (brick hits are written back as empty).
module explosion_controller #(
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned NUM_FLAMES  = 6,
    parameter int unsigned RANGE       = 2,
    parameter int unsigned FLAME_TICKS = 50000000,
    parameter int unsigned MAP_COLS    = 40,
    parameter int unsigned MAP_ROWS    = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        explosion_write_enable,
    input  logic [9:0]  exploding_bomb_x,
    input  logic [9:0]  exploding_bomb_y,
    input  logic [9:0]  v_x,
    input  logic [9:0]  v_y,
    input  logic [1:0]  map_rd_data,
    output logic [10:0] map_addr,
    output logic        map_we,
    output logic [1:0]  map_wr_data,
    output logic        explosion_on,
    output logic        queue_overflow
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned SW = (NUM_FLAMES > 1) ? $clog2(NUM_FLAMES) : 1;
    localparam int unsigned KW = $clog2(RANGE + 1);
    localparam int unsigned TW = 32;
    localparam logic [1:0] TILE_EMPTY = 2'b00;
    localparam logic [1:0] TILE_BRICK = 2'b10;

    typedef enum logic [1:0] {IDLE, PROBE, CHECK} state_t;
    typedef enum logic [1:0] {DIR_R, DIR_L, DIR_D, DIR_U} dir_t;

    // request FIFO (tile coordinates only)
    logic [5:0]  fifo_col [QDEPTH];
    logic [5:0]  fifo_row [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic fifo_full, fifo_empty, push_c, pop_c;

    // flame slots
    logic [NUM_FLAMES-1:0] slot_valid;
    logic [5:0]            slot_col   [NUM_FLAMES];
    logic [5:0]            slot_row   [NUM_FLAMES];
    logic [3:0][KW-1:0]    slot_arm   [NUM_FLAMES];
    logic [TW-1:0]         slot_timer [NUM_FLAMES];
    logic                  free_found;
    logic [SW-1:0]         free_idx;

    // resolution state
    state_t state_q, state_d;
    dir_t   dir_q, dir_d;
    logic [KW-1:0]      k_q, k_d;
    logic [3:0][KW-1:0] arm_q, arm_d;
    logic [5:0]         cur_col, cur_row;
    logic [SW-1:0]      cur_slot;
    logic [6:0]         tcol, trow;
    logic               oob_c, next_dir, done_c, map_we_c, hit_c;
    logic [10:0]        tgt_addr, map_addr_c;
    logic               unused_bits;

    assign unused_bits = ^{exploding_bomb_x[3:0], exploding_bomb_y[3:0], v_x[3:0], v_y[3:0]};

    assign fifo_full  = (count == (PW+1)'(QDEPTH));
    assign fifo_empty = (count == '0);
    assign push_c     = explosion_write_enable && (!fifo_full || pop_c);

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            queue_overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (explosion_write_enable && !push_c) queue_overflow <= 1'b1;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_col[wr_ptr] <= exploding_bomb_x[9:4];
            fifo_row[wr_ptr] <= exploding_bomb_y[9:4];
        end
    end

    // lowest-index free slot; a slot expiring this cycle is still valid, hence busy
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_FLAMES - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    // probe target for the current direction/distance; underflow wraps past the map edge
    always_comb begin
        tcol = {1'b0, cur_col};
        trow = {1'b0, cur_row};
        case (dir_q)
            DIR_R:   tcol = {1'b0, cur_col} + 7'(k_q);
            DIR_L:   tcol = {1'b0, cur_col} - 7'(k_q);
            DIR_D:   trow = {1'b0, cur_row} + 7'(k_q);
            default: trow = {1'b0, cur_row} - 7'(k_q);
        endcase
        oob_c    = (tcol >= 7'(MAP_COLS)) || (trow >= 7'(MAP_ROWS));
        tgt_addr = 11'(trow) * 11'(MAP_COLS) + 11'(tcol);
    end

    // resolution FSM: next state, arm updates and map port drive
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        k_d        = k_q;
        arm_d      = arm_q;
        pop_c      = 1'b0;
        next_dir   = 1'b0;
        done_c     = 1'b0;
        map_we_c   = 1'b0;
        map_addr_c = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && free_found) begin
                    pop_c   = 1'b1;
                    state_d = PROBE;
                    dir_d   = DIR_R;
                    k_d     = KW'(1);
                end
            end
            PROBE: begin
                if (oob_c) begin
                    arm_d[dir_q] = k_q - KW'(1);
                    next_dir     = 1'b1;
                end else begin
                    map_addr_c = tgt_addr;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                map_addr_c = tgt_addr;
                if (map_rd_data == TILE_EMPTY) begin
                    arm_d[dir_q] = k_q;
                    if (k_q < KW'(RANGE)) begin
                        k_d     = k_q + KW'(1);
                        state_d = PROBE;
                    end else begin
                        next_dir = 1'b1;
                    end
                end else if (map_rd_data == TILE_BRICK) begin
                    arm_d[dir_q] = k_q;
`ifdef EXPLOSION_BRICK_CLEAR_EN
                    map_we_c = 1'b1;
`endif
                    next_dir = 1'b1;
                end else begin
                    arm_d[dir_q] = k_q - KW'(1);
                    next_dir     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (next_dir) begin
            k_d = KW'(1);
            if (dir_q == DIR_U) begin
                done_c  = 1'b1;
                state_d = IDLE;
            end else begin
                dir_d   = dir_t'(dir_q + 2'd1);
                state_d = PROBE;
            end
        end
    end

    assign map_addr    = map_addr_c;
    assign map_we      = map_we_c;
    assign map_wr_data = TILE_EMPTY;

    // FSM and working registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            dir_q    <= DIR_R;
            k_q      <= '0;
            arm_q    <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
            cur_slot <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            k_q     <= k_d;
            arm_q   <= pop_c ? '0 : arm_d;
            if (pop_c) begin
                cur_col  <= fifo_col[rd_ptr];
                cur_row  <= fifo_row[rd_ptr];
                cur_slot <= free_idx;
            end
        end
    end

    // slot commit on resolution, then lifetime countdown
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FLAMES; i++) begin
            if (!reset) begin
                slot_valid[i] <= 1'b0;
                slot_timer[i] <= '0;
                slot_col[i]   <= '0;
                slot_row[i]   <= '0;
                slot_arm[i]   <= '0;
            end else if (done_c && (cur_slot == SW'(i))) begin
                slot_valid[i] <= 1'b1;
                slot_timer[i] <= TW'(FLAME_TICKS - 1);
                slot_col[i]   <= cur_col;
                slot_row[i]   <= cur_row;
                slot_arm[i]   <= arm_d;
            end else if (slot_valid[i]) begin
                if (slot_timer[i] == '0) slot_valid[i] <= 1'b0;
                else                     slot_timer[i] <= slot_timer[i] - TW'(1);
            end
        end
    end

    // pixel coverage test against every live flame cross
    always_comb begin
        hit_c = 1'b0;
        for (int i = 0; i < NUM_FLAMES; i++) begin
            if (slot_valid[i]) begin
                hit_c = hit_c
                      | ((v_y[9:4] == slot_row[i])
                         && ({1'b0, v_x[9:4]} + 7'(slot_arm[i][DIR_L]) >= {1'b0, slot_col[i]})
                         && ({1'b0, v_x[9:4]} <= {1'b0, slot_col[i]} + 7'(slot_arm[i][DIR_R])))
                      | ((v_x[9:4] == slot_col[i])
                         && ({1'b0, v_y[9:4]} + 7'(slot_arm[i][DIR_U]) >= {1'b0, slot_row[i]})
                         && ({1'b0, v_y[9:4]} <= {1'b0, slot_row[i]} + 7'(slot_arm[i][DIR_D])));
            end
        end
    end

    // registered pixel flag, one clock behind v_x/v_y
    always_ff @(posedge clk) begin
        if (!reset) explosion_on <= 1'b0;
        else        explosion_on <= hit_c;
    end

endmodule

// File: tb/tb_explosion_controller.sv
// Directed bench for explosion_controller with a short flame lifetime and a
// behavioural 40x30 block map with one-clock read latency.
module tb_explosion_controller;

    localparam int unsigned FT = 120;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [9:0]  bx, by, v_x, v_y;
    logic [1:0]  rd_data;
    logic [10:0] map_addr;
    logic        map_we;
    logic [1:0]  map_wr_data;
    logic        explosion_on;
    logic        queue_overflow;

    logic [1:0]  mem [1200];
    int          we_cnt = 0;
    int          oob_cnt = 0;
    logic [10:0] last_we_addr = '0;
    logic [1:0]  last_we_data = 2'b11;
    int          vectors = 0;
    int          errors = 0;

    explosion_controller #(.FLAME_TICKS(FT)) dut (
        .clk(clk), .reset(reset), .explosion_write_enable(wr_en),
        .exploding_bomb_x(bx), .exploding_bomb_y(by), .v_x(v_x), .v_y(v_y),
        .map_rd_data(rd_data), .map_addr(map_addr), .map_we(map_we),
        .map_wr_data(map_wr_data), .explosion_on(explosion_on),
        .queue_overflow(queue_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // block map: registered read, write strobes recorded but not applied
    always @(posedge clk) begin
        rd_data <= (map_addr < 11'd1200) ? mem[map_addr] : 2'b00;
        if (map_addr >= 11'd1200) oob_cnt <= oob_cnt + 1;
        if (map_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= map_addr;
            last_we_data <= map_wr_data;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
    endtask

    task automatic clear_map();
        for (int i = 0; i < 1200; i++) mem[i] = 2'b00;
    endtask

    task automatic push(input int px, input int py);
        wr_en = 1'b1;
        bx = 10'(px);
        by = 10'(py);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sample_px(input int px, input int py, output logic on);
        v_x = 10'(px);
        v_y = 10'(py);
        @(posedge clk);
        #1 on = explosion_on;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (explosion_on !== 1'b0) begin errors++; $display("FAIL reset_on: got %b want 0", explosion_on); end
        vectors++; if (map_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", map_we); end
        vectors++; if (map_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", map_addr); end
        vectors++; if (map_wr_data !== 2'b00) begin errors++; $display("FAIL reset_wdata: got %b want 00", map_wr_data); end
        vectors++; if (queue_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", queue_overflow); end
    endtask

    task automatic test_open_map();
        int   xs [10];
        int   ys [10];
        logic ex [10];
        logic on;
        int   w0;
        xs = '{192, 208, 160, 128, 112, 160, 160, 160, 160, 176};
        ys = '{175, 160, 160, 160, 160, 192, 208, 128, 112, 176};
        ex = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        clear_map();
        w0 = we_cnt;
        push(160, 160);
        wait_cycles(17);
        for (int i = 0; i < 10; i++) begin
            sample_px(xs[i], ys[i], on);
            vectors++;
            if (on !== ex[i]) begin errors++; $display("FAIL open_px(%0d,%0d): got %b want %b", xs[i], ys[i], on, ex[i]); end
        end
        vectors++; if (we_cnt != w0) begin errors++; $display("FAIL open_we: got %0d writes want 0", we_cnt - w0); end
    endtask

    task automatic test_brick();
        int   xs [4];
        int   ys [4];
        logic ex [4];
        logic on;
        int   w0;
        xs = '{176, 192, 128, 160};
        ys = '{160, 160, 160, 192};
        ex = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        clear_map();
        mem[411] = 2'b10;
        w0 = we_cnt;
        push(160, 160);
        wait_cycles(17);
`ifdef EXPLOSION_BRICK_CLEAR_EN
        vectors++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL brick_we: got %0d writes want 1", we_cnt - w0); end
        vectors++; if (last_we_addr !== 11'd411) begin errors++; $display("FAIL brick_addr: got %0d want 411", last_we_addr); end
        vectors++; if (last_we_data !== 2'b00) begin errors++; $display("FAIL brick_data: got %b want 00", last_we_data); end
`else
        vectors++; if (we_cnt - w0 != 0) begin errors++; $display("FAIL brick_we: got %0d writes want 0", we_cnt - w0); end
`endif
        for (int i = 0; i < 4; i++) begin
            sample_px(xs[i], ys[i], on);
            vectors++;
            if (on !== ex[i]) begin errors++; $display("FAIL brick_px(%0d,%0d): got %b want %b", xs[i], ys[i], on, ex[i]); end
        end
    endtask

    task automatic test_wall();
        int   xs [5];
        int   ys [5];
        logic ex [5];
        logic on;
        xs = '{144, 160, 176, 160, 160};
        ys = '{160, 160, 160, 144, 176};
        ex = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        clear_map();
        mem[409] = 2'b01;
        mem[370] = 2'b11;
        push(160, 160);
        wait_cycles(17);
        for (int i = 0; i < 5; i++) begin
            sample_px(xs[i], ys[i], on);
            vectors++;
            if (on !== ex[i]) begin errors++; $display("FAIL wall_px(%0d,%0d): got %b want %b", xs[i], ys[i], on, ex[i]); end
        end
    endtask

    task automatic test_corners();
        int   xs [8];
        int   ys [8];
        logic ex [8];
        logic on;
        int   o0;
        xs = '{0, 32, 48, 0, 0, 592, 576, 624};
        ys = '{0, 0, 0, 32, 48, 464, 464, 432};
        ex = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        clear_map();
        o0 = oob_cnt;
        push(0, 0);
        wait_cycles(17);
        for (int i = 0; i < 5; i++) begin
            sample_px(xs[i], ys[i], on);
            vectors++;
            if (on !== ex[i]) begin errors++; $display("FAIL corner_px(%0d,%0d): got %b want %b", xs[i], ys[i], on, ex[i]); end
        end
        do_reset();
        push(624, 464);
        wait_cycles(17);
        for (int i = 5; i < 8; i++) begin
            sample_px(xs[i], ys[i], on);
            vectors++;
            if (on !== ex[i]) begin errors++; $display("FAIL corner_px(%0d,%0d): got %b want %b", xs[i], ys[i], on, ex[i]); end
        end
        vectors++; if (oob_cnt != o0) begin errors++; $display("FAIL corner_oob: got %0d out-of-map addresses want 0", oob_cnt - o0); end
    endtask

    task automatic test_back_to_back();
        logic on;
        do_reset();
        clear_map();
        push(80, 80);
        wait_cycles(1);
        push(80, 240);
        push(320, 80);
        push(320, 240);
        push(560, 80);
        push(560, 240);
        vectors++; if (queue_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", queue_overflow); end
        wait_cycles(29);
        sample_px(80, 240, on);
        vectors++; if (on !== 1'b1) begin errors++; $display("FAIL order_second_done: got %b want 1", on); end
        sample_px(320, 80, on);
        vectors++; if (on !== 1'b0) begin errors++; $display("FAIL order_third_pending: got %b want 0", on); end
        wait_cycles(60);
        sample_px(320, 240, on);
        vectors++; if (on !== 1'b1) begin errors++; $display("FAIL order_fourth: got %b want 1", on); end
        sample_px(560, 80, on);
        vectors++; if (on !== 1'b1) begin errors++; $display("FAIL order_fifth: got %b want 1", on); end
        sample_px(560, 240, on);
        vectors++; if (on !== 1'b0) begin errors++; $display("FAIL dropped_push: got %b want 0", on); end
        sample_px(80, 80, on);
        vectors++; if (on !== 1'b1) begin errors++; $display("FAIL order_first: got %b want 1", on); end
        vectors++; if (queue_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", queue_overflow); end
    endtask

    task automatic test_slots_full();
        int   tx [7];
        int   ty [7];
        logic on;
        tx = '{5, 15, 25, 35, 5, 15, 25};
        ty = '{5, 5, 5, 5, 15, 15, 15};
        do_reset();
        clear_map();
        for (int k = 0; k < 7; k++) begin
            push(tx[k] * 16, ty[k] * 16);
            wait_cycles(17);
        end
        sample_px(25 * 16, 15 * 16, on);
        vectors++; if (on !== 1'b0) begin errors++; $display("FAIL slots_seventh_waits: got %b want 0", on); end
        sample_px(5 * 16, 5 * 16, on);
        vectors++; if (on !== 1'b1) begin errors++; $display("FAIL slots_first_alive: got %b want 1", on); end
        wait_cycles(12);
        sample_px(5 * 16, 5 * 16, on);
        vectors++; if (on !== 1'b0) begin errors++; $display("FAIL slots_first_expired: got %b want 0", on); end
        sample_px(25 * 16, 15 * 16, on);
        vectors++; if (on !== 1'b0) begin errors++; $display("FAIL slots_seventh_resolving: got %b want 0", on); end
        wait_cycles(14);
        sample_px(25 * 16, 15 * 16, on);
        vectors++; if (on !== 1'b1) begin errors++; $display("FAIL slots_seventh_live: got %b want 1", on); end
        sample_px(15 * 16, 15 * 16, on);
        vectors++; if (on !== 1'b1) begin errors++; $display("FAIL slots_sixth_live: got %b want 1", on); end
    endtask

    task automatic test_reset_mid();
        logic on;
        int   w0;
        do_reset();
        clear_map();
        mem[370] = 2'b10;
        w0 = we_cnt;
        push(160, 160);
        push(320, 80);
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(1);
        vectors++; if (map_we !== 1'b0) begin errors++; $display("FAIL mid_we: got %b want 0", map_we); end
        vectors++; if (map_addr !== 11'd0) begin errors++; $display("FAIL mid_addr: got %0d want 0", map_addr); end
        vectors++; if (explosion_on !== 1'b0) begin errors++; $display("FAIL mid_on: got %b want 0", explosion_on); end
        vectors++; if (queue_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b want 0", queue_overflow); end
        reset = 1'b1;
        wait_cycles(40);
        sample_px(160, 160, on);
        vectors++; if (on !== 1'b0) begin errors++; $display("FAIL mid_aborted: got %b want 0", on); end
        sample_px(320, 80, on);
        vectors++; if (on !== 1'b0) begin errors++; $display("FAIL mid_fifo_flushed: got %b want 0", on); end
        vectors++; if (we_cnt != w0) begin errors++; $display("FAIL mid_no_write: got %0d writes want 0", we_cnt - w0); end
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0;
        bx    = '0;
        by    = '0;
        v_x   = '0;
        v_y   = '0;
        clear_map();
        @(negedge clk);
        test_reset();
        test_open_map();
        test_brick();
        test_wall();
        test_corners();
        test_back_to_back();
        test_slots_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
